// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, datapath width, PC step and NOP encoding.
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   // Word-align a redirect target.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and feeds IF/ID,
// absorbing stalls, branch redirects and variable memory latency with NOP bubbles.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4_out,
   output logic [31:0] instruction_out,
   output logic        valid_out,
   output logic        flush_out
);
   import fetch_pkg::*;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] hold_q, hold_d;
   logic [XLEN-1:0] pc_plus4;

   assign pc_plus4 = pc_q + PC_STEP;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   // Redirect wins over everything; a response still in flight must be dropped.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      if (redirect_valid) begin
         pc_d = align_word(redirect_pc);
         if (!imem_ready && (state_q != HOLD)) begin
            state_d = DROP;
         end else begin
            state_d = FETCH;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ready) begin
                  if (stall) begin
                     hold_d  = imem_rdata;
                     state_d = HOLD;
                  end else begin
                     pc_d = pc_plus4;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  pc_d    = pc_plus4;
                  state_d = FETCH;
               end
            end
            DROP: begin
               if (imem_ready) begin
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_comb begin
      imem_req        = (state_q != HOLD);
      instruction_out = NOP_INSTR;
      valid_out       = 1'b0;
      if ((state_q == FETCH) && imem_ready) begin
         instruction_out = imem_rdata;
         valid_out       = 1'b1;
      end else if (state_q == HOLD) begin
         instruction_out = hold_q;
         valid_out       = 1'b1;
      end
   end

   assign imem_addr    = pc_q;
   assign pc_out       = pc_q;
   assign pc_plus4_out = pc_plus4;
   assign flush_out    = redirect_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming/latency vectors from a table, then hand sequences
// for stall-hold, redirect-drop, redirect-in-hold, PC wrap and mid-wait reset.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        st;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic [31:0] rd;
      logic        ereq;
      logic [31:0] eaddr;
      logic [31:0] einstr;
      logic        evalid;
      logic        eflush;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;
   logic [31:0] instruction_out;
   logic        valid_out;
   logic        flush_out;

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .pc_out          (pc_out),
      .pc_plus4_out    (pc_plus4_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out),
      .flush_out       (flush_out)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic [31:0] rd, input logic ereq,
                               input logic [31:0] eaddr, input logic [31:0] einstr,
                               input logic evalid, input logic eflush);
      vec_t v;
      v.st = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rd = rd;
      v.ereq = ereq; v.eaddr = eaddr; v.einstr = einstr; v.evalid = evalid; v.eflush = eflush;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic check_out(input string n, input vec_t v);
      chk({n, ".req"},   32'(imem_req),  32'(v.ereq));
      chk({n, ".addr"},  imem_addr,      v.eaddr);
      chk({n, ".pc"},    pc_out,         v.eaddr);
      chk({n, ".pc4"},   pc_plus4_out,   v.eaddr + 32'd4);
      chk({n, ".instr"}, instruction_out, v.einstr);
      chk({n, ".valid"}, 32'(valid_out), 32'(v.evalid));
      chk({n, ".flush"}, 32'(flush_out), 32'(v.eflush));
   endtask

   task automatic drive(input vec_t v);
      stall          = v.st;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      imem_ready     = v.rdy;
      imem_rdata     = v.rd;
   endtask

   // Drive away from the rising edge, sample the combinational view 1 time unit later.
   task automatic step(input string n, input vec_t v);
      @(negedge clk);
      drive(v);
      #1;
      check_out(n, v);
   endtask

   task automatic do_reset(input string n);
      @(negedge clk);
      reset = 1'b1;
      drive(mk(0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, NOP, 0, 0));
      #1;
      check_out(n, mk(0, 0, 0, 0, 0, 1, 32'h0, NOP, 0, 0));
      @(negedge clk);
      reset = 1'b0;
   endtask

   vec_t tbl[10];

   initial begin
      reset = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // streaming with constant ready, then ready every third cycle
      tbl[0] = mk(0, 0, 0, 1, 32'hA000_0000, 1, 32'h00, 32'hA000_0000, 1, 0);
      tbl[1] = mk(0, 0, 0, 1, 32'hA000_0004, 1, 32'h04, 32'hA000_0004, 1, 0);
      tbl[2] = mk(0, 0, 0, 1, 32'hA000_0008, 1, 32'h08, 32'hA000_0008, 1, 0);
      tbl[3] = mk(0, 0, 0, 1, 32'hA000_000C, 1, 32'h0C, 32'hA000_000C, 1, 0);
      tbl[4] = mk(0, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'h10, NOP, 0, 0);
      tbl[5] = mk(0, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'h10, NOP, 0, 0);
      tbl[6] = mk(0, 0, 0, 1, 32'hB000_0010, 1, 32'h10, 32'hB000_0010, 1, 0);
      tbl[7] = mk(0, 0, 0, 0, 32'h0000_0000, 1, 32'h14, NOP, 0, 0);
      tbl[8] = mk(0, 0, 0, 0, 32'h0000_0000, 1, 32'h14, NOP, 0, 0);
      tbl[9] = mk(0, 0, 0, 1, 32'hB000_0014, 1, 32'h14, 32'hB000_0014, 1, 0);

      repeat (2) @(negedge clk);
      #1;
      check_out("reset", mk(0, 0, 0, 0, 0, 1, 32'h0, NOP, 0, 0));
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         step($sformatf("vec%0d", i), tbl[i]);
      end

      // stall on arrival at pc=8 parks the word in HOLD
      do_reset("reset2");
      step("t3.a0",   mk(0, 0, 0, 1, 32'hA000_0000, 1, 32'h0, 32'hA000_0000, 1, 0));
      step("t3.a4",   mk(0, 0, 0, 1, 32'hA000_0004, 1, 32'h4, 32'hA000_0004, 1, 0));
      step("t3.hit",  mk(1, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h8, 32'hDEAD_BEEF, 1, 0));
      step("t3.hold1", mk(1, 0, 0, 0, 32'h0, 0, 32'h8, 32'hDEAD_BEEF, 1, 0));
      step("t3.hold2", mk(1, 0, 0, 0, 32'h0, 0, 32'h8, 32'hDEAD_BEEF, 1, 0));
      step("t3.rel",  mk(0, 0, 0, 0, 32'h0, 0, 32'h8, 32'hDEAD_BEEF, 1, 0));
      step("t3.next", mk(0, 0, 0, 0, 32'h0, 1, 32'hC, NOP, 0, 0));

      // redirect with a request in flight: the late response is dropped
      step("t4.redir", mk(0, 1, 32'h100, 0, 32'h0, 1, 32'hC, NOP, 0, 1));
      step("t4.drop",  mk(0, 0, 0, 1, 32'h1234_5678, 1, 32'h100, NOP, 0, 0));
      step("t4.wait",  mk(0, 0, 0, 0, 32'h0, 1, 32'h100, NOP, 0, 0));
      step("t4.fetch", mk(0, 0, 0, 1, 32'hC000_0100, 1, 32'h100, 32'hC000_0100, 1, 0));

      // redirect while holding, stall asserted: buffered word is lost
      step("t5.hold",  mk(1, 0, 0, 1, 32'hCAFE_0000, 1, 32'h104, 32'hCAFE_0000, 1, 0));
      step("t5.redir", mk(1, 1, 32'h203, 0, 32'h0, 0, 32'h104, 32'hCAFE_0000, 1, 1));
      step("t5.after", mk(1, 0, 0, 0, 32'h0, 1, 32'h200, NOP, 0, 0));

      // wrap of the PC at the top of the address space
      step("t6.redir", mk(0, 1, 32'hFFFF_FFFC, 1, 32'hD000_0200, 1, 32'h200, 32'hD000_0200, 1, 1));
      step("t6.top",   mk(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, NOP, 0, 0));
      step("t6.topr",  mk(0, 0, 0, 1, 32'hE000_FFFC, 1, 32'hFFFF_FFFC, 32'hE000_FFFC, 1, 0));
      step("t6.zero",  mk(0, 0, 0, 0, 32'h0, 1, 32'h0, NOP, 0, 0));
      step("t6.zr",    mk(0, 0, 0, 1, 32'hE000_0000, 1, 32'h0, 32'hE000_0000, 1, 0));
      step("t6.wait",  mk(0, 0, 0, 0, 32'h0, 1, 32'h4, NOP, 0, 0));

      // reset asserted while a fetch is waiting takes effect immediately
      do_reset("t6.rst");
      step("t6.post",  mk(0, 0, 0, 1, 32'h7777_0000, 1, 32'h0, 32'h7777_0000, 1, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
